// File: rtl/uart_tx_framed_if.sv
// Accept handshake and line outputs of the framed UART transmitter.
interface uart_tx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic                 send_enable;
    logic [DATA_BITS-1:0] data_to_send;
    logic                 ready;
    logic                 sending;
    logic                 done;
    logic                 serial_out;

    // Packet/command side: requests frames, observes status and the line.
    modport master (
        output send_enable,
        output data_to_send,
        input  ready,
        input  sending,
        input  done,
        input  serial_out
    );

    // Transmitter side.
    modport slave (
        input  send_enable,
        input  data_to_send,
        output ready,
        output sending,
        output done,
        output serial_out
    );
endinterface

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter: baud divider, start/stop framing,
// optional parity, 1 or 2 stop bits, ready/valid-style accept.
module uart_tx_framed #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_framed_if.slave   tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_framed: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end
    if ($bits(tx.data_to_send) != DATA_BITS) begin : g_bad_if_width
        $error("uart_tx_framed: interface DATA_BITS does not match");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 serial_out_r;
    logic                 ready_r;
    logic                 sending_r;
    logic                 done_r;

    // Frame sequencer: the line bit, status flags and done pulse are all
    // registered here so each output changes only on a clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            serial_out_r <= 1'b1;
            ready_r      <= 1'b1;
            sending_r    <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == S_IDLE) begin
                serial_out_r <= 1'b1;
                if (tx.send_enable) begin
                    shreg        <= tx.data_to_send;
                    // Parity is fixed from the payload at accept time.
                    par_bit      <= (PARITY == 1) ? ~(^tx.data_to_send)
                                                  : (^tx.data_to_send);
                    baud_cnt     <= '0;
                    bit_idx      <= '0;
                    serial_out_r <= 1'b0;
                    ready_r      <= 1'b0;
                    sending_r    <= 1'b1;
                    state        <= S_START;
                end
            end else if (baud_cnt != BAUD_LAST) begin
                baud_cnt <= baud_cnt + CW'(1);
            end else begin
                baud_cnt <= '0;
                case (state)
                    S_START: begin
                        state        <= S_DATA;
                        serial_out_r <= shreg[0];
                    end
                    S_DATA: begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state        <= S_PARITY;
                                serial_out_r <= par_bit;
                            end else begin
                                state        <= S_STOP;
                                serial_out_r <= 1'b1;
                            end
                        end else begin
                            bit_idx      <= bit_idx + IW'(1);
                            shreg        <= shreg >> 1;
                            serial_out_r <= shreg[1];
                        end
                    end
                    S_PARITY: begin
                        state        <= S_STOP;
                        bit_idx      <= '0;
                        serial_out_r <= 1'b1;
                    end
                    S_STOP: begin
                        if (bit_idx == STOP_LAST) begin
                            state     <= S_IDLE;
                            bit_idx   <= '0;
                            done_r    <= 1'b1;
                            ready_r   <= 1'b1;
                            sending_r <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                    default: begin
                        state        <= S_IDLE;
                        serial_out_r <= 1'b1;
                        ready_r      <= 1'b1;
                        sending_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx.serial_out = serial_out_r;
    assign tx.ready      = ready_r;
    assign tx.sending    = sending_r;
    assign tx.done       = done_r;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: four instances at CLKS_PER_BIT=4
// covering no parity, even parity, odd parity and two stop bits.
module tb_uart_tx_framed;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic [3:0] se;
    logic [7:0] dat [4];
    logic [3:0] ser;
    logic [3:0] rdy;
    logic [3:0] snd;
    logic [3:0] dn;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    typedef struct {
        int unsigned dut;
        logic [7:0]  data;
        bit          has_par;
        bit          par;
        int unsigned nstop;
    } vec_t;

    vec_t vecs [10];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int P = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
        localparam int S = (g == 3) ? 2 : 1;

        uart_tx_framed_if #(.DATA_BITS(8)) bus ();

        assign bus.send_enable  = se[g];
        assign bus.data_to_send = dat[g];
        assign ser[g]           = bus.serial_out;
        assign rdy[g]           = bus.ready;
        assign snd[g]           = bus.sending;
        assign dn[g]            = bus.done;

        uart_tx_framed #(
            .DATA_BITS   (8),
            .CLKS_PER_BIT(CPB),
            .PARITY      (P),
            .STOP_BITS   (S)
        ) dut (
            .clk  (clk),
            .reset(reset),
            .tx   (bus.slave)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Called at the cycle after the accept edge (START). Checks every cycle
    // of the frame and finishes on the done cycle, without advancing past it.
    // poke > 0 pulses send_enable with other data at that frame cycle.
    task automatic check_frame(input int unsigned d, input logic [7:0] data,
                               input bit has_par, input bit par,
                               input int unsigned nstop, input int unsigned poke);
        logic        exp_bits [12];
        int unsigned nb;
        int unsigned cyc;
        nb = 0;
        exp_bits[nb] = 1'b0; nb++;
        for (int unsigned i = 0; i < 8; i++) begin
            exp_bits[nb] = data[i]; nb++;
        end
        if (has_par) begin
            exp_bits[nb] = par; nb++;
        end
        for (int unsigned s = 0; s < nstop; s++) begin
            exp_bits[nb] = 1'b1; nb++;
        end
        cyc = 1;
        for (int unsigned b = 0; b < nb; b++) begin
            for (int unsigned c = 0; c < CPB; c++) begin
                if (poke != 0 && cyc == poke) begin
                    se[d]  = 1'b1;
                    dat[d] = 8'hFF;
                end
                if (poke != 0 && cyc == poke + 1) se[d] = 1'b0;
                check("line_bit", 16'(ser[d]), 16'(exp_bits[b]));
                check("sending_in_frame", 16'({snd[d], rdy[d], dn[d]}), 16'b100);
                cyc++;
                tick();
            end
        end
        check("done_cycle", 16'({dn[d], rdy[d], ser[d], snd[d]}), 16'b1110);
    endtask

    task automatic apply_frame(input int unsigned d, input logic [7:0] data,
                               input bit has_par, input bit par,
                               input int unsigned nstop, input int unsigned poke);
        check("ready_before_send", 16'(rdy[d]), 16'h1);
        se[d]  = 1'b1;
        dat[d] = data;
        tick();
        se[d]  = 1'b0;
        dat[d] = ~data;
        check_frame(d, data, has_par, par, nstop, poke);
        tick();
        check("after_done", 16'({dn[d], rdy[d], ser[d], snd[d]}), 16'b0110);
    endtask

    initial begin
        vecs[0] = '{0, 8'h55, 1'b0, 1'b0, 1};
        vecs[1] = '{0, 8'h00, 1'b0, 1'b0, 1};
        vecs[2] = '{0, 8'hFF, 1'b0, 1'b0, 1};
        vecs[3] = '{1, 8'hA3, 1'b1, 1'b0, 1};
        vecs[4] = '{2, 8'hA3, 1'b1, 1'b1, 1};
        vecs[5] = '{1, 8'h01, 1'b1, 1'b1, 1};
        vecs[6] = '{2, 8'h00, 1'b1, 1'b1, 1};
        vecs[7] = '{2, 8'h7F, 1'b1, 1'b0, 1};
        vecs[8] = '{1, 8'h7F, 1'b1, 1'b1, 1};
        vecs[9] = '{3, 8'h5A, 1'b0, 1'b0, 2};

        reset = 1'b1;
        se    = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        tick();
        tick();
        check("reset_state", 16'({ser, rdy, snd, dn}), 16'hFF00);
        reset = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_state", 16'({ser, rdy, snd, dn}), 16'hFF00);
        end

        // Single frames from the table.
        for (int i = 0; i < 10; i++) begin
            apply_frame(vecs[i].dut, vecs[i].data, vecs[i].has_par,
                        vecs[i].par, vecs[i].nstop, 0);
            tick();
        end

        // Back-to-back with send_enable held; payload changed mid-frame.
        se[3]  = 1'b1;
        dat[3] = 8'h00;
        tick();
        dat[3] = 8'hFF;
        check_frame(3, 8'h00, 1'b0, 1'b0, 2, 0);
        tick();
        se[3] = 1'b0;
        check_frame(3, 8'hFF, 1'b0, 1'b0, 2, 0);
        tick();
        check("b2b_after", 16'({dn[3], rdy[3], ser[3], snd[3]}), 16'b0110);
        tick();

        // Reset during DATA bit 3 (payload bit 3 is 0).
        se[0]  = 1'b1;
        dat[0] = 8'hF7;
        tick();
        se[0] = 1'b0;
        for (int i = 1; i < 18; i++) tick();
        check("pre_reset_bit3", 16'({ser[0], snd[0]}), 16'b01);
        reset = 1'b1;
        tick();
        check("mid_reset", 16'({ser[0], rdy[0], snd[0], dn[0]}), 16'b1100);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_idle", 16'({ser[0], rdy[0], snd[0], dn[0]}), 16'b1100);
        end
        apply_frame(0, 8'h3C, 1'b0, 1'b0, 1, 0);
        tick();

        // send_enable pulsed while busy is ignored.
        apply_frame(1, 8'h3C, 1'b1, 1'b0, 1, 10);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("no_queued_frame", 16'({ser[1], rdy[1], snd[1], dn[1]}), 16'b1100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_framed.md
Name: uart_tx_framed

Overview:
Parametrised UART transmitter. Successor to the team's fixed 8-bit, one-bit-per-clock serialiser.
Adds the following over that block:
- On-chip baud divider.
- Start and stop framing.
- Configurable data width, parity and stop-bit count.
- A ready/valid-style accept handshake.
It sits between the packet/command logic and the TX pin of the board UART.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9), sent LSB first
CLKS_PER_BIT, 434, clk cycles per serial bit (>=2); default is 50 MHz / 115200
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
send_enable  input  1  request to transmit data_to_send
data_to_send  input  DATA_BITS  payload; sampled only on the accept cycle
ready  output  1  high when idle and able to accept a frame
sending  output  1  high while a frame is on the line (START through STOP)
done  output  1  one-cycle pulse when a frame completes
serial_out  output  1  TX line, idle high

Behaviour:
- Reset (sampled at a clk edge while reset=1):
  - state=IDLE, serial_out=1, ready=1, sending=0, done=0.
  - Baud counter and bit index are cleared.
  - Reset overrides everything, including mid-frame: the line returns high on the next edge, no partial-frame completion, no done pulse.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Accept:
  - A frame is accepted at an edge where send_enable=1 and ready=1.
  - data_to_send is latched into a shift register at that edge.
  - Later changes to data_to_send or send_enable have no effect on the frame in flight.
- Line timing:
  - Latency is one cycle: after the accept edge, state=START and serial_out=0.
  - Each bit holds for exactly CLKS_PER_BIT cycles.
  - Baud counter: counts 0..CLKS_PER_BIT-1; the bit advances when count==CLKS_PER_BIT-1; the counter reloads to 0 on every bit boundary.
  - Counter width is $clog2(CLKS_PER_BIT).
- Bit sequence:
  - START: 1 bit of value 0.
  - DATA: DATA_BITS bits, shift register bit 0 first.
  - PARITY (only when PARITY!=0): even = XOR of all data bits; odd = inverted XOR.
  - STOP: STOP_BITS bits of value 1.
- Frame length is F = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits, i.e. F*CLKS_PER_BIT cycles.
- Completion:
  - On the last cycle of the final stop bit the next edge moves to IDLE.
  - In that IDLE cycle done=1 for exactly one cycle, ready=1, serial_out=1.
- ready = (state==IDLE). sending = (state!=IDLE).
- serial_out is driven from a register; glitch-free.
- Back-to-back:
  - If send_enable is held high, the next frame is accepted at the edge ending the done cycle.
  - The line therefore stays high for exactly one clk cycle between frames (stop bits are never shortened).
- send_enable=1 while busy: ignored; it is not queued.
- Illegal parameters (DATA_BITS outside 5..9, CLKS_PER_BIT<2, PARITY>2, STOP_BITS not 1/2) are rejected by a generate-time $error.

Test Plan:
1. Reset then idle, send_enable=0 for 100 cycles -> serial_out=1, ready=1, sending=0, done never pulses.
2. CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0x55 (1-cycle send_enable) -> serial_out per 4-cycle bit = 0,1,0,1,0,1,0,1,0,1; sending high for 40 cycles; done pulses on cycle 41 after the accept edge.
3. PARITY=2 (even), then PARITY=1 (odd); send 0xA3 -> parity bit 0 (even) and 1 (odd) after data bits 1,1,0,0,0,1,0,1; frame 44 cycles at CLKS_PER_BIT=4.
4. STOP_BITS=2, send_enable held high, payloads 0x00 then 0xFF -> two complete frames; each line-high stop period is 8 cycles, plus exactly 1 idle cycle between frames; data_to_send changed mid-frame does not corrupt frame 1.
5. Assert reset during DATA bit 3 of a frame -> serial_out=1 and ready=1 on the next edge; no done pulse; the next request produces a clean full frame.
6. send_enable pulsed while sending=1 -> ignored; exactly one frame is transmitted and one done pulse is seen.
